// File: rtl/fb_swap_ctrl_pkg.sv
// Shared definitions for the frame-buffer swap controller: FSM state
// encoding, default buffer base addresses and the beat counter width.
package fb_swap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RENDER  = 2'd0,
    ST_WAIT_VB = 2'd1,
    ST_SWAP    = 2'd2
  } fb_state_e;

  localparam logic [23:0] FB_BASE0_DEF = 24'h000000;
  localparam logic [23:0] FB_BASE1_DEF = 24'h100000;
  localparam int          BEAT_W       = 20;

endpackage

// File: rtl/fb_swap_ctrl_rise_det.sv
// Rising-edge detector: one delay flop and an AND gate. The output is
// combinational and is high for the cycle in which sig_i is first seen high.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Double-buffer scheduler: holds the render pipeline after each frame until the
// next display vblank, then swaps front/back bases. Tracks frame statistics.
module fb_swap_ctrl
  import fb_swap_ctrl_pkg::*;
#(
  parameter int                H_DISP     = 1280,
  parameter int                V_DISP     = 720,
  parameter int                ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] FB_BASE0   = ADDR_W'(FB_BASE0_DEF),
  parameter logic [ADDR_W-1:0] FB_BASE1   = ADDR_W'(FB_BASE1_DEF),
  parameter logic [15:0]       REPEAT_MAX = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_done,
  input  logic              disp_vblank,
  input  logic              ppl_wr_valid,
  input  logic              cfg_single,
  output logic              ppl_hold,
  output logic [ADDR_W-1:0] wr_base,
  output logic [ADDR_W-1:0] rd_base,
  output logic              buf_sel,
  output logic              swap_done,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       repeat_cnt,
  output logic              err_frame,
  output logic [1:0]        dbg_state
);

  localparam logic [BEAT_W-1:0] FRAME_BEATS = BEAT_W'(H_DISP * V_DISP);

  fb_state_e         state_q, state_d;
  logic              fd_rise, vb_rise;
  logic              ppl_hold_q, ppl_hold_d;
  logic              swap_done_q, swap_done_d;
  logic              buf_sel_q, buf_sel_d;
  logic              err_q, err_d;
  logic [15:0]       frame_q, frame_d;
  logic [15:0]       rep_q, rep_d;
  logic [BEAT_W-1:0] beat_q, beat_d;

  rise_det u_fd_rise (.clk(clk), .rst(rst), .sig_i(frame_done),  .rise_o(fd_rise));
  rise_det u_vb_rise (.clk(clk), .rst(rst), .sig_i(disp_vblank), .rise_o(vb_rise));

  // Flow control: a ppl_wr_valid beat is accepted only while the FSM is in
  // RENDER; ppl_hold is the registered stall that covers WAIT_VB and the SWAP
  // cycle that follows it. Beats or frame ends outside RENDER are dropped
  // and latch err_frame.
  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    rep_d     = rep_q;
    beat_d    = beat_q;
    err_d     = err_q;
    buf_sel_d = buf_sel_q;
    unique case (state_q)
      ST_RENDER: begin
        if (fd_rise) begin
          frame_d = frame_q + 16'd1;
          if (beat_q != FRAME_BEATS) err_d = 1'b1;
          beat_d = BEAT_W'(ppl_wr_valid);
          if (!cfg_single) state_d = vb_rise ? ST_SWAP : ST_WAIT_VB;
        end else begin
          if (ppl_wr_valid) beat_d = beat_q + BEAT_W'(1);
          if (vb_rise && (rep_q != REPEAT_MAX)) rep_d = rep_q + 16'd1;
        end
      end
      ST_WAIT_VB: begin
        if (vb_rise) state_d = ST_SWAP;
        if (ppl_wr_valid || fd_rise) err_d = 1'b1;
      end
      ST_SWAP: begin
        buf_sel_d = ~buf_sel_q;
        state_d   = ST_RENDER;
        if (ppl_wr_valid || fd_rise) err_d = 1'b1;
      end
      default: state_d = ST_RENDER;
    endcase
    // A coincident frame end and vblank goes straight to SWAP without a stall.
    ppl_hold_d  = (state_d == ST_WAIT_VB) ||
                  ((state_d == ST_SWAP) && (state_q == ST_WAIT_VB));
    swap_done_d = (state_d == ST_SWAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RENDER;
      ppl_hold_q  <= 1'b0;
      swap_done_q <= 1'b0;
      buf_sel_q   <= 1'b0;
      err_q       <= 1'b0;
      frame_q     <= 16'd0;
      rep_q       <= 16'd0;
      beat_q      <= '0;
    end else begin
      state_q     <= state_d;
      ppl_hold_q  <= ppl_hold_d;
      swap_done_q <= swap_done_d;
      buf_sel_q   <= buf_sel_d;
      err_q       <= err_d;
      frame_q     <= frame_d;
      rep_q       <= rep_d;
      beat_q      <= beat_d;
    end
  end

  assign rd_base    = buf_sel_q ? FB_BASE1 : FB_BASE0;
  assign wr_base    = cfg_single ? rd_base : (buf_sel_q ? FB_BASE0 : FB_BASE1);
  assign ppl_hold   = ppl_hold_q;
  assign swap_done  = swap_done_q;
  assign buf_sel    = buf_sel_q;
  assign frame_cnt  = frame_q;
  assign repeat_cnt = rep_q;
  assign err_frame  = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Bench for fb_swap_ctrl with a reduced frame size; expectations come from
// frame/gap bookkeeping (hold = gap+1, buf_sel = frames mod 2, ...).
module tb_fb_swap_ctrl;

  localparam int          H           = 8;
  localparam int          V           = 4;
  localparam int          FRAME_BEATS = H * V;
  localparam logic [23:0] B0          = 24'h000000;
  localparam logic [23:0] B1          = 24'h100000;
  localparam logic [15:0] REP_MAX     = 16'd20;

  logic        clk = 1'b0;
  logic        rst, frame_done, disp_vblank, ppl_wr_valid, cfg_single;
  logic        ppl_hold, buf_sel, swap_done, err_frame;
  logic [23:0] wr_base, rd_base;
  logic [15:0] frame_cnt, repeat_cnt;
  logic [1:0]  dbg_state;

  int tests_run = 0;
  int fails     = 0;
  int obs_hold  = 0;
  int obs_swap  = 0;
  logic [0:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  fb_swap_ctrl #(
    .H_DISP(H), .V_DISP(V), .ADDR_W(24),
    .FB_BASE0(B0), .FB_BASE1(B1), .REPEAT_MAX(REP_MAX)
  ) dut (
    .clk(clk), .rst(rst), .frame_done(frame_done), .disp_vblank(disp_vblank),
    .ppl_wr_valid(ppl_wr_valid), .cfg_single(cfg_single), .ppl_hold(ppl_hold),
    .wr_base(wr_base), .rd_base(rd_base), .buf_sel(buf_sel), .swap_done(swap_done),
    .frame_cnt(frame_cnt), .repeat_cnt(repeat_cnt), .err_frame(err_frame),
    .dbg_state(dbg_state)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    obs_hold += int'(ppl_hold);
    obs_swap += int'(swap_done);
  endtask

  task automatic do_reset();
    rst = 1'b1; frame_done = 1'b0; disp_vblank = 1'b0; ppl_wr_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    obs_hold = 0; obs_swap = 0;
  endtask

  task automatic send_beats(input int n);
    for (int i = 0; i < n; i++) begin
      while ($urandom_range(0, 3) == 0) tick();
      ppl_wr_valid = 1'b1;
      tick();
      ppl_wr_valid = 1'b0;
    end
  endtask

  // gap = cycles from frame_done rise to vblank rise; 0 means coincident.
  task automatic run_frame(input int beats, input int gap);
    int fd_len, vb_len;
    send_beats(beats);
    obs_hold = 0; obs_swap = 0;
    fd_len = $urandom_range(1, 3);
    frame_done = 1'b1;
    if (gap == 0) disp_vblank = 1'b1;
    tick();
    for (int j = 1; j < gap; j++) begin
      if (j >= fd_len) frame_done = 1'b0;
      tick();
    end
    if (gap > 0) begin
      disp_vblank = 1'b1;
      tick();
    end
    vb_len = $urandom_range(2, 4);
    for (int j = 0; j < vb_len; j++) tick();
    disp_vblank = 1'b0; frame_done = 1'b0;
    tick(); tick();
  endtask

  task automatic vb_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      disp_vblank = 1'b1; tick(); tick();
      disp_vblank = 1'b0; tick(); tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    cfg_single = 1'b0;
    do_reset();
    tests_run++; if (ppl_hold !== 1'b0) begin fails++; $display("FAIL reset_hold: got %0b want 0", ppl_hold); end
    tests_run++; if (buf_sel !== 1'b0) begin fails++; $display("FAIL reset_buf_sel: got %0b want 0", buf_sel); end
    tests_run++; if (swap_done !== 1'b0) begin fails++; $display("FAIL reset_swap_done: got %0b want 0", swap_done); end
    tests_run++; if (rd_base !== B0) begin fails++; $display("FAIL reset_rd_base: got %h want %h", rd_base, B0); end
    tests_run++; if (wr_base !== B1) begin fails++; $display("FAIL reset_wr_base: got %h want %h", wr_base, B1); end
    tests_run++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    tests_run++; if (repeat_cnt !== 16'd0) begin fails++; $display("FAIL reset_repeat_cnt: got %0d want 0", repeat_cnt); end
    tests_run++; if (err_frame !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", err_frame); end
    tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    cfg_single = 1'b1; #1;
    tests_run++; if (wr_base !== B0) begin fails++; $display("FAIL reset_single_wr_base: got %h want %h", wr_base, B0); end
    cfg_single = 1'b0; #1;
  endtask

  task automatic test_nominal();
    int gap;
    do_reset();
    run_frame(FRAME_BEATS, 50);
    tests_run++; if (obs_hold != 51) begin fails++; $display("FAIL nominal_hold_cycles: got %0d want 51", obs_hold); end
    tests_run++; if (obs_swap != 1) begin fails++; $display("FAIL nominal_swaps: got %0d want 1", obs_swap); end
    tests_run++; if (buf_sel !== 1'b1) begin fails++; $display("FAIL nominal_buf_sel: got %0b want 1", buf_sel); end
    tests_run++; if (rd_base !== B1) begin fails++; $display("FAIL nominal_rd_base: got %h want %h", rd_base, B1); end
    tests_run++; if (wr_base !== B0) begin fails++; $display("FAIL nominal_wr_base: got %h want %h", wr_base, B0); end
    tests_run++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL nominal_frame_cnt: got %0d want 1", frame_cnt); end
    tests_run++; if (err_frame !== 1'b0) begin fails++; $display("FAIL nominal_err: got %0b want 0", err_frame); end
    tests_run++; if (repeat_cnt !== 16'd0) begin fails++; $display("FAIL nominal_repeat: got %0d want 0", repeat_cnt); end
    for (int f = 0; f < 3; f++) begin
      gap = $urandom_range(1, 30);
      run_frame(FRAME_BEATS, gap);
      tests_run++; if (obs_hold != gap + 1) begin fails++; $display("FAIL nominal_rand_hold: gap %0d got %0d want %0d", gap, obs_hold, gap + 1); end
      tests_run++; if (obs_swap != 1) begin fails++; $display("FAIL nominal_rand_swaps: got %0d want 1", obs_swap); end
    end
    tests_run++; if (buf_sel !== 1'b0) begin fails++; $display("FAIL nominal_final_sel: got %0b want 0", buf_sel); end
    tests_run++; if (frame_cnt !== 16'd4) begin fails++; $display("FAIL nominal_final_frames: got %0d want 4", frame_cnt); end
  endtask

  task automatic test_slow_render();
    int n;
    do_reset();
    vb_pulses(3);
    tests_run++; if (repeat_cnt !== 16'd3) begin fails++; $display("FAIL slow_repeat3: got %0d want 3", repeat_cnt); end
    tests_run++; if (obs_swap != 0) begin fails++; $display("FAIL slow_no_swap: got %0d want 0", obs_swap); end
    tests_run++; if (buf_sel !== 1'b0) begin fails++; $display("FAIL slow_buf_sel: got %0b want 0", buf_sel); end
    n = $urandom_range(2, 6);
    vb_pulses(n);
    tests_run++; if (repeat_cnt !== 16'(3 + n)) begin fails++; $display("FAIL slow_repeat_rand: got %0d want %0d", repeat_cnt, 3 + n); end
    vb_pulses(int'(REP_MAX) + 5);
    tests_run++; if (repeat_cnt !== REP_MAX) begin fails++; $display("FAIL slow_saturate: got %0d want %0d", repeat_cnt, REP_MAX); end
    run_frame(FRAME_BEATS, 5);
    tests_run++; if (obs_swap != 1) begin fails++; $display("FAIL slow_then_swap: got %0d want 1", obs_swap); end
    tests_run++; if (repeat_cnt !== REP_MAX) begin fails++; $display("FAIL slow_sat_hold: got %0d want %0d", repeat_cnt, REP_MAX); end
  endtask

  task automatic test_coincident();
    do_reset();
    send_beats(FRAME_BEATS);
    obs_hold = 0; obs_swap = 0;
    frame_done = 1'b1; disp_vblank = 1'b1;
    tick();
    tests_run++; if (swap_done !== 1'b1) begin fails++; $display("FAIL coinc_swap_pulse: got %0b want 1", swap_done); end
    tests_run++; if (buf_sel !== 1'b0) begin fails++; $display("FAIL coinc_sel_early: got %0b want 0", buf_sel); end
    tick();
    tests_run++; if (buf_sel !== 1'b1) begin fails++; $display("FAIL coinc_sel_toggle: got %0b want 1", buf_sel); end
    tests_run++; if (swap_done !== 1'b0) begin fails++; $display("FAIL coinc_swap_end: got %0b want 0", swap_done); end
    tick(); tick();
    frame_done = 1'b0; disp_vblank = 1'b0;
    tick(); tick();
    tests_run++; if (obs_hold != 0) begin fails++; $display("FAIL coinc_hold: got %0d want 0", obs_hold); end
    tests_run++; if (obs_swap != 1) begin fails++; $display("FAIL coinc_swaps: got %0d want 1", obs_swap); end
    tests_run++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL coinc_frames: got %0d want 1", frame_cnt); end
  endtask

  task automatic test_integrity();
    // short frame
    do_reset();
    send_beats(FRAME_BEATS - 1);
    tests_run++; if (err_frame !== 1'b0) begin fails++; $display("FAIL integ_pre_short: got %0b want 0", err_frame); end
    frame_done = 1'b1; tick();
    tests_run++; if (err_frame !== 1'b1) begin fails++; $display("FAIL integ_short: got %0b want 1", err_frame); end
    frame_done = 1'b0; tick();
    disp_vblank = 1'b1; tick(); tick(); tick();
    disp_vblank = 1'b0; tick(); tick();
    run_frame(FRAME_BEATS, 3);
    tests_run++; if (err_frame !== 1'b1) begin fails++; $display("FAIL integ_sticky: got %0b want 1", err_frame); end
    do_reset();
    tests_run++; if (err_frame !== 1'b0) begin fails++; $display("FAIL integ_rst_clear: got %0b want 0", err_frame); end
    // long frame
    run_frame(FRAME_BEATS + 1, 2);
    tests_run++; if (err_frame !== 1'b1) begin fails++; $display("FAIL integ_long: got %0b want 1", err_frame); end
    // write beat while held
    do_reset();
    send_beats(FRAME_BEATS);
    frame_done = 1'b1; tick();
    tests_run++; if (err_frame !== 1'b0) begin fails++; $display("FAIL integ_exact: got %0b want 0", err_frame); end
    ppl_wr_valid = 1'b1; tick(); ppl_wr_valid = 1'b0;
    tests_run++; if (err_frame !== 1'b1) begin fails++; $display("FAIL integ_beat_in_wait: got %0b want 1", err_frame); end
    disp_vblank = 1'b1; tick(); tick(); tick();
    disp_vblank = 1'b0; frame_done = 1'b0; tick(); tick();
    tests_run++; if (buf_sel !== 1'b1) begin fails++; $display("FAIL integ_swap_still: got %0b want 1", buf_sel); end
    // second frame end while held is dropped
    do_reset();
    send_beats(FRAME_BEATS);
    frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
    frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
    tests_run++; if (err_frame !== 1'b1) begin fails++; $display("FAIL integ_fd_in_wait: got %0b want 1", err_frame); end
    tests_run++; if (frame_cnt !== 16'd1) begin fails++; $display("FAIL integ_fd_dropped: got %0d want 1", frame_cnt); end
    disp_vblank = 1'b1; tick(); tick(); tick();
    disp_vblank = 1'b0; tick(); tick();
  endtask

  task automatic test_single();
    cfg_single = 1'b1;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      send_beats(FRAME_BEATS);
      frame_done = 1'b1; tick(); frame_done = 1'b0; tick();
    end
    tests_run++; if (obs_hold != 0) begin fails++; $display("FAIL single_hold: got %0d want 0", obs_hold); end
    tests_run++; if (obs_swap != 0) begin fails++; $display("FAIL single_swaps: got %0d want 0", obs_swap); end
    tests_run++; if (frame_cnt !== 16'd4) begin fails++; $display("FAIL single_frames: got %0d want 4", frame_cnt); end
    tests_run++; if (buf_sel !== 1'b0) begin fails++; $display("FAIL single_buf_sel: got %0b want 0", buf_sel); end
    tests_run++; if (wr_base !== B0) begin fails++; $display("FAIL single_wr_base: got %h want %h", wr_base, B0); end
    tests_run++; if (rd_base !== B0) begin fails++; $display("FAIL single_rd_base: got %h want %h", rd_base, B0); end
    tests_run++; if (err_frame !== 1'b0) begin fails++; $display("FAIL single_err: got %0b want 0", err_frame); end
    cfg_single = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    run_frame(FRAME_BEATS, 4);
    send_beats(FRAME_BEATS);
    frame_done = 1'b1; tick(); tick();
    tests_run++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL rmid_in_wait: got %0d want 1", dbg_state); end
    rst = 1'b1; frame_done = 1'b0; tick();
    tests_run++; if (ppl_hold !== 1'b0) begin fails++; $display("FAIL rmid_hold: got %0b want 0", ppl_hold); end
    tests_run++; if (buf_sel !== 1'b0) begin fails++; $display("FAIL rmid_buf_sel: got %0b want 0", buf_sel); end
    tests_run++; if (frame_cnt !== 16'd0) begin fails++; $display("FAIL rmid_frames: got %0d want 0", frame_cnt); end
    tests_run++; if (dbg_state !== 2'd0) begin fails++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end
    rst = 1'b0; tick();
    obs_swap = 0;
    disp_vblank = 1'b1; tick(); tick(); tick();
    disp_vblank = 1'b0; tick();
    tests_run++; if (obs_swap != 0) begin fails++; $display("FAIL rmid_no_swap: got %0d want 0", obs_swap); end
    tests_run++; if (repeat_cnt !== 16'd1) begin fails++; $display("FAIL rmid_repeat: got %0d want 1", repeat_cnt); end
  endtask

  task automatic test_back_to_back();
    int nfr, gap, exp_hold;
    logic [0:0] exp_sel;
    do_reset();
    nfr = $urandom_range(5, 8);
    for (int f = 1; f <= nfr; f++) begin
      gap = $urandom_range(0, 6);
      exp_hold = (gap == 0) ? 0 : gap + 1;
      exp_q.push_back(1'(f % 2));
      run_frame(FRAME_BEATS, gap);
      exp_sel = exp_q.pop_front();
      tests_run++; if (obs_hold != exp_hold) begin fails++; $display("FAIL b2b_hold: frame %0d gap %0d got %0d want %0d", f, gap, obs_hold, exp_hold); end
      tests_run++; if (obs_swap != 1) begin fails++; $display("FAIL b2b_swaps: frame %0d got %0d want 1", f, obs_swap); end
      tests_run++; if (buf_sel !== exp_sel) begin fails++; $display("FAIL b2b_buf_sel: frame %0d got %0b want %0b", f, buf_sel, exp_sel); end
    end
    tests_run++; if (frame_cnt !== 16'(nfr)) begin fails++; $display("FAIL b2b_frames: got %0d want %0d", frame_cnt, nfr); end
    tests_run++; if (err_frame !== 1'b0) begin fails++; $display("FAIL b2b_err: got %0b want 0", err_frame); end
    tests_run++; if (repeat_cnt !== 16'd0) begin fails++; $display("FAIL b2b_repeat: got %0d want 0", repeat_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; frame_done = 1'b0; disp_vblank = 1'b0;
    ppl_wr_valid = 1'b0; cfg_single = 1'b0;
    test_reset();
    test_nominal();
    test_slow_render();
    test_coincident();
    test_integrity();
    test_single();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
